// File: rtl/encoder16to4_stream.sv
`default_nettype none
// ============================================================================
//  Module      : encoder16to4_stream
//  Description : One-hot to binary index encoder with zero/multi-hot flagging
//                and a small valid/ready output FIFO. Optional saturating
//                invalid-word counter enabled by defining ENC_ERR_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder16to4_stream #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 4,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           err_count
);

    localparam int                c_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0]  c_FULL   = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W:0]  c_ONE    = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = (c_PTR_W)'(1);

    // ------------------------------------------------------------------
    // Combinational encode: lowest set bit wins, any extra bit flags err
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] w_idx;
    logic                 w_found;
    logic                 w_multi;
    logic                 w_err;

    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (in[i]) begin
                if (w_found) begin
                    w_multi = 1'b1;
                end else begin
                    w_found = 1'b1;
                    w_idx   = i[OUT_WIDTH-1:0];
                end
            end
        end
        w_err = !w_found || w_multi;
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] r_mem_idx [DEPTH];
    logic                 r_mem_err [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    assign in_ready  = !w_full || out_ready;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Storage is not reset; gating with out_valid keeps out/out_err at zero
    // whenever the buffer is empty, including right after reset.
    assign out     = out_valid ? r_mem_idx[r_rd_ptr] : '0;
    assign out_err = out_valid ? r_mem_err[r_rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem_idx[r_wr_ptr] <= w_idx;
            r_mem_err[r_wr_ptr] <= w_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Invalid-word counter, counted at input acceptance
    // ------------------------------------------------------------------
`ifdef ENC_ERR_COUNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= 8'h00;
        end else if (w_push && w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_encoder16to4_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder16to4_stream
//  Description : Scoreboard bench for encoder16to4_stream with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder16to4_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  err_count;

    encoder16to4_stream #(
        .IN_WIDTH (16),
        .OUT_WIDTH(4),
        .DEPTH    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .out_err  (out_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] idx;
        logic       err;
        int         cyc;
        bit         strict;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a head word shown with out_ready=1 transfers at the next edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got out=%0h err=%0b with empty scoreboard", out, out_err);
            end else begin
                e = q.pop_front();
                check("out_idx", {28'd0, out}, {28'd0, e.idx});
                check("out_err", {31'd0, out_err}, {31'd0, e.err});
                if (e.strict) check("latency", cyc, e.cyc + 1);
            end
        end
    end

    task automatic push(input logic [15:0] w, input logic [3:0] idx, input logic err,
                        input bit strict, output int waited);
        bit done;
        done   = 1'b0;
        waited = 0;
        in       = w;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{idx, err, cyc, strict});
                done = 1'b1;
            end else if (waited >= 20) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: got in_ready=0 for 20 cycles, expected 1 (word %0h)", w);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", q.size(), 0);
    endtask

    function automatic logic [7:0] exp_cnt(input logic [7:0] n);
`ifdef ENC_ERR_COUNT_EN
        return n;
`else
        return 8'h00 & n;
`endif
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        int w;
        logic [15:0] word;
        rst = 1'b1; in = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out", {28'd0, out}, 0);
        check("rst_out_err", {31'd0, out_err}, 0);
        check("rst_err_count", {24'd0, err_count}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;

        // Sweep of every one-hot position, back-to-back
        for (int i = 0; i < 16; i++) begin
            word = 16'h0001 << i;
            push(word, i[3:0], 1'b0, 1'b1, w);
        end
        drain();

        // Zero and multi-hot words
        push(16'h0000, 4'd0, 1'b1, 1'b1, w);
        push(16'h0014, 4'd2, 1'b1, 1'b1, w);
        drain();
        check("err_count_invalid", {24'd0, err_count}, {24'd0, exp_cnt(8'd2)});

        // Backpressure: fill, hold third word, then release
        out_ready = 1'b0;
        push(16'h0100, 4'd8, 1'b0, 1'b0, w);
        push(16'h8000, 4'd15, 1'b0, 1'b0, w);
        in = 16'h0002; in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready", {31'd0, in_ready}, 0);
        check("bp_head", {28'd0, out}, 8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_hold_out", {28'd0, out}, 8);
        check("bp_hold_valid", {31'd0, out_valid}, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(16'h0002, 4'd1, 1'b0, 1'b0, w);
        drain();

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0;
        push(16'h0001, 4'd0, 1'b0, 1'b0, w);
        push(16'h0010, 4'd4, 1'b0, 1'b0, w);
        @(negedge clk);
        check("full_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(16'h0040, 4'd6, 1'b0, 1'b0, w);
        check("full_same_edge_accept", w, 0);
        out_ready = 1'b0;
        @(negedge clk);
        check("full_count_kept", {31'd0, in_ready}, 0);
        check("full_head_after", {28'd0, out}, 4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset with two words buffered
        out_ready = 1'b0;
        push(16'h0003, 4'd0, 1'b1, 1'b0, w);
        push(16'h0004, 4'd2, 1'b0, 1'b0, w);
        @(negedge clk);
        check("pre_rst_valid", {31'd0, out_valid}, 1);
        check("pre_rst_err_count", {24'd0, err_count}, {24'd0, exp_cnt(8'd3)});
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, out_valid}, 0);
        check("mid_rst_out", {28'd0, out}, 0);
        check("mid_rst_err_count", {24'd0, err_count}, 0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(16'h0008, 4'd3, 1'b0, 1'b1, w);
        drain();

        // Counter saturation
        for (int i = 0; i < 300; i++) push(16'hFFFF, 4'd0, 1'b1, 1'b1, w);
        drain();
        check("sat_err_count", {24'd0, err_count}, {24'd0, exp_cnt(8'hFF)});
        push(16'hFFFF, 4'd0, 1'b1, 1'b1, w);
        drain();
        check("sat_hold", {24'd0, err_count}, {24'd0, exp_cnt(8'hFF)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
